stn_capture: RTL
================

# stn_capture

Captures the DragonBall STN LCD controller bus (LCK, LLP, LFLM, LD[3:0]) by oversampling it in the system clock domain. It converts each 4-pixel nibble into a single-cycle framebuffer write with a linear nibble address. It also measures the incoming frame geometry. It sits between the LCD connector pins and the framebuffer write port, and feeds geometry debug values to the pixel generator.

## Interface
Parameters:
- MAX_WIDTH, 640: maximum pixels per line; must be a multiple of 4.
- MAX_HEIGHT, 480: maximum lines per frame.
- ADDR_W, 17: framebuffer nibble address width; must satisfy 2^ADDR_W ≥ MAX_WIDTH*MAX_HEIGHT/4.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  synchronous reset, active-high.
- lck  in  1  LCD shift clock, asynchronous to clk.
- llp  in  1  LCD line pulse, asynchronous.
- lflm  in  1  LCD first-line marker, asynchronous.
- ld  in  4  LCD pixel nibble, asynchronous.
- fb_we  out  1  framebuffer write strobe, one clk wide.
- fb_addr  out  ADDR_W  framebuffer nibble address.
- fb_data  out  4  framebuffer write data.
- frame_width  out  10  pixels in the last line of the last completed frame.
- frame_height  out  9  lines in the last completed frame.
- frame_x  out  10  live pixel position in the current line.
- frame_y  out  9  live line index in the current frame.
- frame_valid  out  1  high once at least one complete frame has been measured.
- overflow  out  1  sticky flag: input exceeded MAX_WIDTH or MAX_HEIGHT.

## Operation
- Synchronisation: lck, llp, lflm and ld[3:0] each pass through two flip-flops, then one history register for edge detection.
- Events, detected on the synchronised signals:
  - PIX: falling edge of lck.
  - EOL: falling edge of llp.
  - SOF: rising edge of lflm.
- ld is captured from the same synchroniser stage used for PIX detection.
- Counters:
  - x_cnt (10 bits) counts pixels and steps by 4 per PIX.
  - y_cnt (9 bits) counts lines.
  - line_base (ADDR_W bits) steps by MAX_WIDTH/4 per line.
  - No multiplier is used for addressing.
- State machine:
  - WAIT_SOF: PIX and EOL are ignored. SOF clears x_cnt, y_cnt and line_base, then moves to ACTIVE.
  - ACTIVE, on PIX:
    - If x_cnt < MAX_WIDTH and y_cnt < MAX_HEIGHT: fb_we=1, fb_addr = line_base + x_cnt/4, fb_data = captured ld, then x_cnt += 4.
    - Otherwise: no write, overflow <= 1, x_cnt saturates at 1023.
  - ACTIVE, on EOL:
    - last_width <= x_cnt.
    - x_cnt <= 0.
    - y_cnt += 1, saturating at 511.
    - line_base += MAX_WIDTH/4, held at its current value once y_cnt ≥ MAX_HEIGHT.
  - ACTIVE, on SOF:
    - frame_width <= last_width.
    - frame_height <= y_cnt.
    - frame_valid <= 1.
    - Counters and line_base clear; state stays ACTIVE.
- Simultaneous events in one clk are applied in the order PIX, then EOL, then SOF:
  - The nibble belongs to the ending line.
  - A line ending with SOF is counted in frame_height.
  - A concurrent SOF and EOL give frame_width = the x_cnt of that line.
- frame_x = x_cnt and frame_y = y_cnt, both registered.
- overflow clears only on rst.
- rst mid-frame:
  - State returns to WAIT_SOF.
  - Every output goes to 0 on the next clk edge.
  - Synchroniser registers clear to 0, so an lflm that is high at release produces SOF.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, frame_width=0, frame_height=0, frame_x=0, frame_y=0, frame_valid=0, overflow=0.
- Latency: a pin transition sampled at clk edge N is flagged as an event at edge N+2, and its outputs are registered at edge N+3.
  - fb_we is high for exactly the one cycle following edge N+3.
  - fb_addr and fb_data are valid in that same cycle.
- Input requirements:
  - lck high and low phases each ≥ 2 clk periods.
  - ld stable from 2 clk before to 1 clk after the lck falling edge.
  - llp and lflm pulses ≥ 2 clk wide.
  - Narrower pulses may be missed; no other behaviour is guaranteed for them.
- Throughput: at most one write per clk. No backpressure; the framebuffer port must accept a write every cycle.

## Test plan
- Reset then 3 lines of 8 PIX each, with ld = 1,2,…, SOF first and SOF again at the end:
  - 24 fb_we pulses.
  - Addresses 0–7, 160–167 and 320–327 with matching data.
  - frame_width=32, frame_height=3, frame_valid=1.
- PIX and EOL before any SOF: no fb_we; frame_x and frame_y stay 0.
- 170 PIX in one line (680 pixels): 160 writes, then overflow=1 and no write at address ≥ line_base+160.
- 485 lines: writes stop after line 479, overflow=1, frame_height=485.
- PIX, EOL and SOF falling in the same clk: the write occurs at the old line's address, the line is counted in frame_height, and frame_width includes that nibble.
- rst pulse in the middle of a line: all outputs are 0 next cycle; capture resumes only after the next SOF.

Source files
------------

// File: rtl/stn_capture.sv
// DragonBall STN LCD bus capture: oversamples LCK/LLP/LFLM/LD in the clk domain,
// turns each pixel nibble into a framebuffer write and measures frame geometry.
module stn_capture #(
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lck,
    input  logic              llp,
    input  logic              lflm,
    input  logic [3:0]        ld,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_data,
    output logic [9:0]        frame_width,
    output logic [8:0]        frame_height,
    output logic [9:0]        frame_x,
    output logic [8:0]        frame_y,
    output logic              frame_valid,
    output logic              overflow
);
    localparam logic [9:0]        MAX_W_C     = 10'(MAX_WIDTH);
    localparam logic [8:0]        MAX_H_C     = 9'(MAX_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP_C = ADDR_W'(MAX_WIDTH / 4);
    localparam int                LCK_B       = 4;
    localparam int                LLP_B       = 5;
    localparam int                LFLM_B      = 6;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        pin_s1_q, pin_s1_d;
    logic [6:0]        pin_s2_q, pin_s2_d;
    logic [6:0]        pin_h_q, pin_h_d;
    logic              pix_ev_q, pix_ev_d;
    logic              eol_ev_q, eol_ev_d;
    logic              sof_ev_q, sof_ev_d;
    logic [3:0]        ld_ev_q, ld_ev_d;
    logic [9:0]        x_cnt_q, x_cnt_d;
    logic [8:0]        y_cnt_q, y_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [9:0]        last_width_q, last_width_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [3:0]        fb_data_q, fb_data_d;
    logic [9:0]        frame_width_q, frame_width_d;
    logic [8:0]        frame_height_q, frame_height_d;
    logic              frame_valid_q, frame_valid_d;
    logic              overflow_q, overflow_d;

    // Two-stage synchroniser, edge history and registered event flags
    always_comb begin
        pin_s1_d = {lflm, llp, lck, ld};
        pin_s2_d = pin_s1_q;
        pin_h_d  = pin_s2_q;
        pix_ev_d = pin_h_q[LCK_B] & ~pin_s2_q[LCK_B];
        eol_ev_d = pin_h_q[LLP_B] & ~pin_s2_q[LLP_B];
        sof_ev_d = ~pin_h_q[LFLM_B] & pin_s2_q[LFLM_B];
        ld_ev_d  = pin_s2_q[3:0];
    end

    // Next-state logic: any SOF enters ACTIVE, which is then held until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_SOF: begin
                if (sof_ev_q) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_WAIT_SOF;
        endcase
    end

    // Datapath: events applied in PIX, EOL, SOF order within one cycle
    always_comb begin
        x_cnt_d        = x_cnt_q;
        y_cnt_d        = y_cnt_q;
        line_base_d    = line_base_q;
        last_width_d   = last_width_q;
        fb_we_d        = 1'b0;
        fb_addr_d      = fb_addr_q;
        fb_data_d      = fb_data_q;
        frame_width_d  = frame_width_q;
        frame_height_d = frame_height_q;
        frame_valid_d  = frame_valid_q;
        overflow_d     = overflow_q;
        case (state_q)
            ST_WAIT_SOF: begin
                if (sof_ev_q) begin
                    x_cnt_d     = 10'd0;
                    y_cnt_d     = 9'd0;
                    line_base_d = {ADDR_W{1'b0}};
                end else begin
                    x_cnt_d     = x_cnt_q;
                end
            end
            ST_ACTIVE: begin
                if (pix_ev_q) begin
                    if ((x_cnt_q < MAX_W_C) && (y_cnt_q < MAX_H_C)) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = line_base_q + ADDR_W'(x_cnt_q[9:2]);
                        fb_data_d = ld_ev_q;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    x_cnt_d = (x_cnt_q >= 10'd1020) ? 10'd1023 : x_cnt_q + 10'd4;
                end else begin
                    x_cnt_d = x_cnt_q;
                end
                if (eol_ev_q) begin
                    last_width_d = x_cnt_d;
                    x_cnt_d      = 10'd0;
                    // Base stops advancing past the last visible line
                    if (y_cnt_d < MAX_H_C) begin
                        line_base_d = line_base_q + LINE_STEP_C;
                    end else begin
                        line_base_d = line_base_q;
                    end
                    y_cnt_d = (y_cnt_q == 9'd511) ? 9'd511 : y_cnt_q + 9'd1;
                end else begin
                    last_width_d = last_width_q;
                end
                if (sof_ev_q) begin
                    frame_width_d  = last_width_d;
                    frame_height_d = y_cnt_d;
                    frame_valid_d  = 1'b1;
                    x_cnt_d        = 10'd0;
                    y_cnt_d        = 9'd0;
                    line_base_d    = {ADDR_W{1'b0}};
                end else begin
                    frame_valid_d  = frame_valid_q;
                end
            end
            default: begin
                x_cnt_d     = 10'd0;
                y_cnt_d     = 9'd0;
                line_base_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchroniser and event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_s1_q <= 7'd0;
            pin_s2_q <= 7'd0;
            pin_h_q  <= 7'd0;
            pix_ev_q <= 1'b0;
            eol_ev_q <= 1'b0;
            sof_ev_q <= 1'b0;
            ld_ev_q  <= 4'd0;
        end else begin
            pin_s1_q <= pin_s1_d;
            pin_s2_q <= pin_s2_d;
            pin_h_q  <= pin_h_d;
            pix_ev_q <= pix_ev_d;
            eol_ev_q <= eol_ev_d;
            sof_ev_q <= sof_ev_d;
            ld_ev_q  <= ld_ev_d;
        end
    end

    // Counters, write port and geometry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q        <= 10'd0;
            y_cnt_q        <= 9'd0;
            line_base_q    <= {ADDR_W{1'b0}};
            last_width_q   <= 10'd0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= {ADDR_W{1'b0}};
            fb_data_q      <= 4'd0;
            frame_width_q  <= 10'd0;
            frame_height_q <= 9'd0;
            frame_valid_q  <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            x_cnt_q        <= x_cnt_d;
            y_cnt_q        <= y_cnt_d;
            line_base_q    <= line_base_d;
            last_width_q   <= last_width_d;
            fb_we_q        <= fb_we_d;
            fb_addr_q      <= fb_addr_d;
            fb_data_q      <= fb_data_d;
            frame_width_q  <= frame_width_d;
            frame_height_q <= frame_height_d;
            frame_valid_q  <= frame_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_data      = fb_data_q;
    assign frame_width  = frame_width_q;
    assign frame_height = frame_height_q;
    assign frame_x      = x_cnt_q;
    assign frame_y      = y_cnt_q;
    assign frame_valid  = frame_valid_q;
    assign overflow     = overflow_q;

endmodule
